// File: rtl/onehot_req_encoder.sv
// Sequential 8-to-3 request encoder: accumulates decoder request lines and
// drains them lowest-index-first as 3-bit codes over a valid/ready handshake.
module onehot_req_encoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req_in,
  input  logic       load,
  output logic [2:0] code_out,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] pending,
  output logic       empty,
  output logic       ovf
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] pend_q;
  logic [2:0] code_q;
  logic       ovf_q;

  logic       take;
  logic       slot_free;
  logic       pop;
  logic       capture;
  logic [2:0] sel;
  logic [7:0] pop_mask;
  logic [7:0] kept;

  assign valid     = (state == S_HOLD);
  assign take      = valid & ready;
  assign slot_free = ~valid | take;
  assign pop       = slot_free & en & (pend_q != 8'h00);
  assign capture   = en & load;

  // Downward scan so the lowest set bit is the last (winning) assignment.
  always_comb begin
    sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pend_q[i]) sel = 3'(i);
    end
  end

  assign pop_mask = pop ? (8'h01 << sel) : 8'h00;
  assign kept     = pend_q & ~pop_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_EMPTY;
      pend_q <= 8'h00;
      code_q <= 3'd0;
      ovf_q  <= 1'b0;
    end else begin
      if (pop) begin
        code_q <= sel;
        state  <= S_HOLD;
      end else if (take) begin
        state  <= S_EMPTY;
      end
      // A re-request of the bit being popped survives and is not a collision.
      if (capture) begin
        pend_q <= kept | req_in;
        if ((req_in & kept) != 8'h00) ovf_q <= 1'b1;
      end else begin
        pend_q <= kept;
      end
    end
  end

  assign code_out = code_q;
  assign pending  = pend_q;
  assign ovf      = ovf_q;
  assign empty    = ~valid & (pend_q == 8'h00);

endmodule

// File: tb/tb_onehot_req_encoder.sv
// Scoreboard bench for onehot_req_encoder: directed scenarios followed by
// randomized traffic, compared against a set-based reference model.
module tb_onehot_req_encoder;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req_in;
  logic       load;
  logic [2:0] code_out;
  logic       valid;
  logic       ready;
  logic [7:0] pending;
  logic       empty;
  logic       ovf;

  onehot_req_encoder dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req_in   (req_in),
    .load     (load),
    .code_out (code_out),
    .valid    (valid),
    .ready    (ready),
    .pending  (pending),
    .empty    (empty),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] p;
    logic       v;
    logic       o;
    logic       e;
    logic [2:0] c;
  } status_t;

  status_t    status_q[$];
  logic [2:0] code_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model: the pending requests as a set of indices plus the
  // code currently offered to the consumer.
  bit         m_init  = 0;
  bit         m_set[8];
  bit         m_valid;
  int         m_code;
  bit         m_ovf;

  function automatic logic [7:0] set_to_bits();
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 8; i++) if (m_set[i]) b[i] = 1'b1;
    return b;
  endfunction

  function automatic int set_count();
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) if (m_set[i]) n++;
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit l,
                               input logic [7:0] q, input bit rd);
    bit         n_set[8];
    bit         n_valid;
    int         n_code;
    bit         n_ovf;
    bit         take;
    bit         popping;
    int         lowest;
    status_t    s;

    rst    = r;
    en     = e;
    load   = l;
    req_in = q;
    ready  = rd;

    if (m_init) begin
      s.p = set_to_bits();
      s.v = m_valid;
      s.o = m_ovf;
      s.e = !m_valid && (set_count() == 0);
      s.c = 3'(m_code);
      status_q.push_back(s);
      if (m_valid && rd) code_q.push_back(3'(m_code));
    end

    if (r) begin
      for (int i = 0; i < 8; i++) n_set[i] = 0;
      n_valid = 0;
      n_code  = 0;
      n_ovf   = 0;
    end else begin
      for (int i = 0; i < 8; i++) n_set[i] = m_set[i];
      n_valid = m_valid;
      n_code  = m_code;
      n_ovf   = m_ovf;
      take    = m_valid && rd;
      popping = (!m_valid || take) && e && (set_count() != 0);
      lowest  = -1;
      for (int i = 0; i < 8; i++) if (m_set[i] && lowest < 0) lowest = i;
      if (popping) begin
        n_set[lowest] = 0;
        n_valid       = 1;
        n_code        = lowest;
      end else if (take) begin
        n_valid = 0;
      end
      if (e && l) begin
        for (int i = 0; i < 8; i++) begin
          if (q[i]) begin
            if (n_set[i]) n_ovf = 1;
            n_set[i] = 1;
          end
        end
      end
    end

    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) m_set[i] = n_set[i];
    m_valid = n_valid;
    m_code  = n_code;
    m_ovf   = n_ovf;
    if (r) m_init = 1;
  endtask

  // Monitor: compares visible status each cycle and every accepted code.
  initial begin
    status_t s;
    forever begin
      @(negedge clk);
      if (status_q.size() > 0) begin
        s = status_q.pop_front();
        checkOutput("pending",  32'(pending),  32'(s.p));
        checkOutput("valid",    32'(valid),    32'(s.v));
        checkOutput("ovf",      32'(ovf),      32'(s.o));
        checkOutput("empty",    32'(empty),    32'(s.e));
        checkOutput("code_out", 32'(code_out), 32'(s.c));
      end
      if (valid === 1'b1 && ready === 1'b1) begin
        if (code_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL take_unexpected: got code %0d expected no transfer at %0t", code_out, $time);
        end else begin
          checkOutput("take_code", 32'(code_out), 32'(code_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] q;
    rst = 1'b1; en = 1'b0; load = 1'b0; req_in = 8'h00; ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset and idle.
    applyStimulus(1, 0, 0, 8'h00, 0);
    applyStimulus(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 8'h00, 1);

    // Single one-hot request.
    applyStimulus(0, 1, 1, 8'b0010_0000, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 8'h00, 1);

    // Multi-hot drain.
    applyStimulus(0, 1, 1, 8'b1000_0101, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 8'h00, 1);

    // Back-pressure.
    applyStimulus(0, 1, 1, 8'b0000_0110, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 8'h00, 1);

    // Re-request of the bit being popped, then collision.
    applyStimulus(0, 1, 1, 8'h01, 1);
    applyStimulus(0, 1, 1, 8'h01, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 8'h00, 1);
    applyStimulus(0, 1, 1, 8'h01, 0);
    applyStimulus(0, 1, 1, 8'h01, 0);
    applyStimulus(0, 1, 1, 8'h01, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 8'h00, 1);

    // Enable gating with a held code.
    applyStimulus(0, 1, 1, 8'h0C, 0);
    applyStimulus(0, 0, 0, 8'h00, 0);
    applyStimulus(0, 0, 1, 8'hFF, 0);
    applyStimulus(0, 0, 1, 8'hFF, 1);
    applyStimulus(0, 0, 0, 8'h00, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 8'h00, 1);

    // Reset mid-drain.
    applyStimulus(0, 1, 1, 8'hF0, 1);
    applyStimulus(0, 1, 0, 8'h00, 1);
    applyStimulus(0, 1, 0, 8'h00, 1);
    applyStimulus(1, 1, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 8'h00, 1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(1, 0) == 1) q = 8'h01 << $urandom_range(7, 0);
      else q = 8'($urandom);
      applyStimulus($urandom_range(99, 0) == 0, $urandom_range(9, 0) != 0,
                    $urandom_range(2, 0) == 0, q, $urandom_range(9, 0) < 7);
    end

    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 0, 8'h00, 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("scoreboard_drained", 32'(code_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/onehot_req_encoder.md
# onehot_req_encoder

Sequential 8-to-3 request encoder that sits directly downstream of `decoder_3x8` and consumes its 8-bit one-hot (or multi-hot) `y_out` lines. Captured request bits accumulate in a pending register. The block drains them lowest-index-first as 3-bit codes over a valid/ready handshake, so a consumer receives one binary index per transfer. It restores the binary form that the decoder expanded, and tolerates bursts, back-pressure and overlapping requests.

## Interface
- No parameters; input width fixed at 8, code width fixed at 3.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  block enable; gates capture and pop.
- `req_in`  in  8  request lines (decoder `y_out`).
- `load`  in  1  capture strobe for `req_in`.
- `code_out`  out  3  index of the granted request bit.
- `valid`  out  1  `code_out` holds an untaken code.
- `ready`  in  1  consumer accepts `code_out`.
- `pending`  out  8  requests captured but not yet presented.
- `empty`  out  1  `pending == 0` and `valid == 0`.
- `ovf`  out  1  sticky collision flag.

## Operation
- The block has one clock; reset is synchronous and active-high.
- Registers: `pending[7:0]`, `code_q[2:0]`, `valid_q`, `ovf_q`. All outputs are driven directly from registers or simple combinational terms of registers.
- Two-state output FSM:
  - EMPTY (`valid=0`).
  - HOLD (`valid=1`).
- `take = valid & ready`.
- `slot_free = ~valid | take`.
- Pop condition: `slot_free & en & (pending != 0)`.
  - On a pop, `sel` = index of the lowest set bit of `pending` (bit 0 has highest priority).
  - Next cycle: `code_q <= sel`, `valid_q <= 1`, and bit `sel` is cleared from `pending`.
- No pop, but `take` is true: `valid_q <= 0` (HOLD -> EMPTY).
- HOLD with `~ready`: `code_q` and `valid_q` are held unchanged. `code_out` must not change while `valid & ~ready`.
- Capture happens when `en & load`. The pending register updates as `pending <= (pending & ~popmask) | req_in`.
  - A bit being popped in the same cycle that is also present in `req_in` stays set (re-request wins).
- Collision: `ovf_q <= 1` when `en & load & |(req_in & pending & ~popmask)`. `ovf` is cleared only by `rst`.
- `req_in` may be multi-hot; every set bit is queued.
- `req_in = 0` with `load` is a no-op.
- `en = 0`:
  - No capture and no pop.
  - An outstanding `valid` can still complete its handshake; on `take`, `valid` drops.
  - `pending` is frozen.
- `empty = ~valid_q & (pending == 0)`.

## Timing
- Reset (synchronous; `rst` sampled high at an edge): after that edge `pending=0`, `code_out=0`, `valid=0`, `ovf=0`, `empty=1`.
- Reset mid-operation discards all pending and held codes; it needs no handshake.
- Latency: with `load` sampled at edge k into an empty block, `pending` updates after edge k. `valid=1` follows after edge k+1 with the lowest index.
- Throughput: one code per cycle while `ready=1`. N set bits drain in N consecutive cycles.
- After the last code is taken with nothing pending, `valid` is low the following cycle.
- Simultaneous `load` and pop in one cycle are both honoured per the update equation above.
- Wrap-around: none. When `pending` reaches 0, the FSM returns to EMPTY.

## Test plan
- Reset and idle: assert `rst` for 2 cycles -> `valid=0`, `code_out=0`, `pending=0`, `ovf=0`, `empty=1`. With `en=1` and no `load` for 10 cycles, the outputs are unchanged.
- Single one-hot input: `req_in=8'b0010_0000`, `load=1` for 1 cycle, `ready=1` -> `valid=1` with `code_out=5` two edges after `load`. One cycle later: `valid=0`, `empty=1`.
- Multi-hot drain: `req_in=8'b1000_0101`, `ready=1` -> `code_out` = 0, 2, 7 on three consecutive valid cycles; `pending` steps 8'h84 -> 8'h80 -> 8'h00.
- Back-pressure: queue 8'b0000_0110 with `ready=0` for 4 cycles -> `code_out=1` and `valid=1` stay stable. Raise `ready` -> code 2 follows on the next cycle, then `valid=0`.
- Collision and re-request:
  - `load` 8'h01, then `load` 8'h01 again while bit 0 is still pending -> `ovf=1`, and it stays 1 until `rst`.
  - Separately, `load` of the bit being popped in the same cycle -> that bit stays in `pending` and is presented again; `ovf` stays 0.
- Enable gating and reset mid-operation:
  - With `en=0`, `load` 8'hFF -> `pending` unchanged. A held `valid` is still taken on `ready`, then drops.
  - With 8'hF0 queued and `rst` pulsed for 1 cycle mid-drain -> all outputs return to reset values after that edge.
